// File: rtl/pulse_sequencer.sv
// pulse_sequencer: per-period scheduler producing RF gate, receiver blank and sync from shadowed pulse_control settings.
// Define PULSE_SEQ_PHASE_EN to enable the mod-4 phase-cycling counter on the phase port.
module pulse_sequencer #(
  parameter int PER_W = 24,
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PER_W-1:0] per,
  input  logic [SEG_W-1:0] p1wid,
  input  logic [SEG_W-1:0] del,
  input  logic [SEG_W-1:0] p2wid,
  input  logic [7:0]       cp,
  input  logic [7:0]       nut_w,
  input  logic [SEG_W-1:0] nut_d,
  input  logic             pu,
  input  logic             bl,
  input  logic [7:0]       p_bl,
  input  logic             rxd,
  output logic             pulse,
  output logic             blank,
  output logic             sync,
  output logic             busy,
  output logic [1:0]       phase
);
  localparam int LEN_W = SEG_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_NUT, S_NGAP, S_P1, S_GAP1, S_P2, S_GAP2, S_HOLD
  } state_t;

  state_t           r_state, w_state_nxt, w_chain_state;
  logic [LEN_W-1:0] r_seg, w_seg_nxt, w_chain_len;
  logic [7:0]       r_rep, w_rep_nxt, w_chain_rep;
  logic             w_chain_done;

  logic [PER_W-1:0] r_cnt, r_per_sh, w_per_eff;
  logic [SEG_W-1:0] r_p1_sh, r_del_sh, r_p2_sh, r_nd_sh;
  logic [7:0]       r_cp_sh, r_nw_sh, r_pbl_sh, r_hcnt;
  logic             r_pu_sh, r_bl_sh, r_win;
  logic             r_pulse, r_blank, r_sync;

  logic [SEG_W-1:0] w_p1, w_del, w_p2, w_nd;
  logic [7:0]       w_cp, w_nw;
  logic             w_start, w_halt, w_force0;
  logic             w_pul_cur, w_p2_any, w_more;
  logic             w_pulse_d, w_blank_d, w_sync_d;

  assign w_halt    = (r_cnt == '0) && (per == '0);
  assign w_start   = (r_cnt == '0) && (per != '0) && !rxd;
  assign w_force0  = rxd || w_halt || w_start;
  assign w_per_eff = w_start ? per : r_per_sh;

  // At period start the shadows are loading this edge, so the chain must see the live inputs.
  assign w_p1  = w_start ? p1wid : r_p1_sh;
  assign w_del = w_start ? del   : r_del_sh;
  assign w_p2  = w_start ? p2wid : r_p2_sh;
  assign w_nd  = w_start ? nut_d : r_nd_sh;
  assign w_cp  = w_start ? cp    : r_cp_sh;
  assign w_nw  = w_start ? nut_w : r_nw_sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_seg   <= '0;
      r_rep   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_seg   <= w_seg_nxt;
      r_rep   <= w_rep_nxt;
    end
  end

  // Walk forward past zero-length segments so they cost no cycles; the chain is at most six steps long.
  always_comb begin
    w_chain_state = w_start ? S_IDLE : r_state;
    w_chain_rep   = w_start ? '0 : r_rep;
    w_chain_len   = '0;
    w_chain_done  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!w_chain_done) begin
        case (w_chain_state)
          S_IDLE: w_chain_state = S_NUT;
          S_NUT:  w_chain_state = S_NGAP;
          S_NGAP: w_chain_state = S_P1;
          S_P1:   w_chain_state = S_GAP1;
          S_GAP1: begin
            if ((w_cp == '0) || ((w_p2 == '0) && (w_del == '0))) begin
              w_chain_state = S_HOLD;
            end else begin
              w_chain_state = S_P2;
              w_chain_rep   = w_cp - 8'd1;
            end
          end
          S_P2:   w_chain_state = (w_chain_rep == '0) ? S_HOLD : S_GAP2;
          S_GAP2: begin
            w_chain_state = S_P2;
            w_chain_rep   = w_chain_rep - 8'd1;
          end
          default: w_chain_state = S_HOLD;
        endcase
        case (w_chain_state)
          S_NUT:   w_chain_len = LEN_W'(w_nw);
          S_NGAP:  w_chain_len = (w_nw != '0) ? LEN_W'(w_nd) : '0;
          S_P1:    w_chain_len = LEN_W'(w_p1);
          S_GAP1:  w_chain_len = (w_cp != '0) ? LEN_W'(w_del) : '0;
          S_P2:    w_chain_len = LEN_W'(w_p2);
          S_GAP2:  w_chain_len = {w_del, 1'b0};
          default: w_chain_len = '0;
        endcase
        w_chain_done = (w_chain_state == S_HOLD) || (w_chain_len != '0);
      end
    end

    w_state_nxt = r_state;
    w_seg_nxt   = r_seg;
    w_rep_nxt   = r_rep;
    if (rxd || w_halt) begin
      w_state_nxt = S_IDLE;
      w_seg_nxt   = '0;
      w_rep_nxt   = '0;
    end else if (w_start || (busy && (r_seg == '0))) begin
      w_state_nxt = w_chain_state;
      w_seg_nxt   = (w_chain_len == '0) ? '0 : w_chain_len - LEN_W'(1);
      w_rep_nxt   = w_chain_rep;
    end else if (busy) begin
      w_seg_nxt   = r_seg - LEN_W'(1);
    end
  end

  always_comb begin
    w_pul_cur = (r_state == S_NUT) || (r_state == S_P2) || ((r_state == S_P1) && r_pu_sh);
    w_p2_any  = (r_cp_sh != '0) && (r_p2_sh != '0);
    case (r_state)
      S_NGAP:         w_more = (r_pu_sh && (r_p1_sh != '0)) || w_p2_any;
      S_P1, S_GAP1:   w_more = w_p2_any;
      S_GAP2:         w_more = w_p2_any;
      default:        w_more = 1'b0;
    endcase
    // Blank spans the whole pulse train; the hold-off only counts once no pulse remains.
    w_pulse_d = !w_force0 && w_pul_cur;
    w_blank_d = !w_force0 && r_bl_sh &&
                (w_pul_cur || (r_win && (w_more || (r_hcnt < r_pbl_sh))));
    w_sync_d  = w_start;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_per_sh <= '0;
      r_p1_sh  <= '0;
      r_del_sh <= '0;
      r_p2_sh  <= '0;
      r_cp_sh  <= '0;
      r_nw_sh  <= '0;
      r_nd_sh  <= '0;
      r_pu_sh  <= 1'b0;
      r_bl_sh  <= 1'b0;
      r_pbl_sh <= '0;
      r_pulse  <= 1'b0;
      r_blank  <= 1'b0;
      r_sync   <= 1'b0;
      r_win    <= 1'b0;
      r_hcnt   <= '0;
    end else begin
      if (rxd || w_halt || (r_cnt == w_per_eff - PER_W'(1))) r_cnt <= '0;
      else                                                    r_cnt <= r_cnt + PER_W'(1);
      if (w_start) begin
        r_per_sh <= per;
        r_p1_sh  <= p1wid;
        r_del_sh <= del;
        r_p2_sh  <= p2wid;
        r_cp_sh  <= cp;
        r_nw_sh  <= nut_w;
        r_nd_sh  <= nut_d;
        r_pu_sh  <= pu;
        r_bl_sh  <= bl;
        r_pbl_sh <= p_bl;
      end
      r_pulse <= w_pulse_d;
      r_blank <= w_blank_d;
      r_sync  <= w_sync_d;
      r_win   <= w_force0 ? 1'b0 : (r_win | w_pul_cur);
      if (w_force0 || w_pul_cur) r_hcnt <= '0;
      else if (r_hcnt != '1)     r_hcnt <= r_hcnt + 8'd1;
    end
  end

  assign pulse = r_pulse;
  assign blank = r_blank;
  assign sync  = r_sync;
  assign busy  = (r_state != S_IDLE) && (r_state != S_HOLD);

`ifdef PULSE_SEQ_PHASE_EN
  logic [1:0] r_phase;
  always_ff @(posedge clk) begin
    if (!rst_n)       r_phase <= '0;
    else if (rxd)     r_phase <= '0;
    else if (w_start) r_phase <= r_phase + 2'd1;
  end
  assign phase = r_phase;
`else
  assign phase = 2'b00;
`endif

endmodule
